btb_update_ctrl: RTL and testbench
==================================

// Module: btb_update_ctrl
// PURPOSE
//  Decode-stage branch resolver. It drives the update/RAS port of the fetch-side BTB.
//  It compares the prediction bundle carried with each instruction against the resolved
//  outcome, classifies the result, and emits exactly one registered BTB update.
//  On a mispredict it raises a held redirect to IF until IF acknowledges it.
//  It also keeps saturating branch and mispredict counters for perf.
// PARAMETERS
//  IDXW   5   width of the BTB entry index carried with the prediction
//  CNTW   32  width of the performance counters
// PORTS
//  clk             in   1     clock; the block uses this single clock
//  reset           in   1     synchronous, active-high
//  flush           in   1     exception/ertn flush from WB
//  br_valid        in   1     instruction presented for resolution
//  br_ready        out  1     block can accept; high only in IDLE
//  br_pc           in   32    instruction PC
//  br_type         in   3     0 NONE, 1 COND, 2 JUMP(b), 3 CALL(bl), 4 RET(jirl ra), 5 JIRL(other)
//  br_taken        in   1     resolved direction; forced 1 for types 2-5
//  br_target       in   32    resolved target
//  pred_en         in   1     BTB hit at fetch (ret_en)
//  pred_taken      in   1     predicted direction
//  pred_target     in   32    predicted target (ret_pc)
//  pred_index      in   IDXW  BTB entry index (ret_index)
//  operate_en      out  1     BTB update strobe
//  operate_pc      out  32    PC of the updated instruction
//  operate_index   out  IDXW  entry to update
//  add_entry, delete_entry, pre_error, pre_right, target_error  out 1 each; one-hot when operate_en
//  right_orien     out  1     resolved direction
//  right_target    out  32    resolved target
//  push_ras        out  1     CALL resolved
//  pop_ras         out  1     RET resolved
//  redirect_valid  out  1     IF must refetch from redirect_pc
//  redirect_pc     out  32    correct next PC
//  redirect_ack    in   1     IF has taken the redirect
//  br_cnt          out  CNTW  resolved branches (type != NONE)
//  miss_cnt        out  CNTW  mispredicts
// BEHAVIOUR
//  - Reset: state IDLE. All outputs are 0 except br_ready=1. Counters are 0.
//  - Accept is br_valid && br_ready && !flush. All update outputs are registered.
//    They are valid in the cycle after accept and last exactly 1 cycle.
//  - Next-PC arithmetic is 32-bit and wraps. pred_next = (pred_en&&pred_taken) ? pred_target : br_pc+4.
//    act_next = br_taken ? br_target : br_pc+4. mispredict = pred_next != act_next.
//  - Classification, first match wins:
//    1. NONE with pred_en: delete_entry (false hit).
//    2. NONE without pred_en: no operate_en.
//    3. Branch with !pred_en and br_taken: add_entry.
//    4. Branch with !pred_en and !br_taken: no operate_en.
//    5. pred_taken != br_taken: pre_error.
//    6. Taken and pred_target != br_target and type != RET: target_error.
//    7. Otherwise: pre_right.
//    RET is excluded from rule 6 because the RAS supplies its target; a RET target miss still redirects.
//  - push_ras = (type==CALL) and pop_ras = (type==RET). Both only with operate_en.
//    operate_en is additionally forced to 1 for CALL/RET even when rule 4 would suppress it.
//  - operate_index = pred_index. The add slot is chosen inside the BTB.
//  - FSM:
//    IDLE -> REDIR on accept with mispredict. redirect_valid=1 and redirect_pc=act_next from the next cycle.
//    REDIR holds redirect_valid/redirect_pc stable. REDIR -> IDLE on redirect_ack.
//    Ack in the first REDIR cycle is legal: redirect is 1 cycle wide.
//  - flush has priority in any state. The next state is IDLE and redirect_valid drops next cycle.
//    An accept in the flush cycle is blocked, so no update is issued.
//    An update already registered, issued the cycle after an earlier accept, is still issued.
//  - Counters increment in the update cycle and saturate at all-ones.
//  - br_ready=0 throughout REDIR, so back-to-back mispredicts serialise.
// TESTING
//  1. COND at 0x1c000100, pred miss, taken to 0x1c000200 -> add_entry=1, redirect_pc=0x1c000200, miss_cnt=1.
//  2. COND, pred hit idx 3 taken to 0x1c000200, resolved not taken -> pre_error, right_orien=0, redirect_pc=0x1c000104.
//  3. CALL at 0x1c000300 hit correct, then RET hit -> push_ras then pop_ras, pre_right, no redirect.
//  4. NONE at 0x1c000400 with pred_en, pred_taken=1 -> delete_entry, redirect_pc=0x1c000404, br_cnt unchanged.
//  5. Mispredict, hold redirect_ack=0 for 5 cycles -> redirect stable, br_ready=0. Assert flush -> IDLE, redirect_valid=0 next cycle.
//  6. Preload counters to all-ones-1 and run 3 mispredicts -> counters saturate at all-ones. br_pc=0xFFFFFFFC not taken -> act_next=0.

Source files
------------

// File: rtl/btb_update_ctrl_if.sv
// Resolver <-> BTB/IF bundle: resolution request, prediction bundle, BTB update port,
// IF redirect handshake and perf counters.
interface btb_update_ctrl_if #(
  parameter int IDXW = 5,
  parameter int CNTW = 32
);
  logic            flush;
  logic            br_valid;
  logic            br_ready;
  logic [31:0]     br_pc;
  logic [2:0]      br_type;
  logic            br_taken;
  logic [31:0]     br_target;
  logic            pred_en;
  logic            pred_taken;
  logic [31:0]     pred_target;
  logic [IDXW-1:0] pred_index;
  logic            operate_en;
  logic [31:0]     operate_pc;
  logic [IDXW-1:0] operate_index;
  logic            add_entry;
  logic            delete_entry;
  logic            pre_error;
  logic            pre_right;
  logic            target_error;
  logic            right_orien;
  logic [31:0]     right_target;
  logic            push_ras;
  logic            pop_ras;
  logic            redirect_valid;
  logic [31:0]     redirect_pc;
  logic            redirect_ack;
  logic [CNTW-1:0] br_cnt;
  logic [CNTW-1:0] miss_cnt;

  modport slave (
    input  flush, br_valid, br_pc, br_type, br_taken, br_target,
           pred_en, pred_taken, pred_target, pred_index, redirect_ack,
    output br_ready, operate_en, operate_pc, operate_index, add_entry, delete_entry,
           pre_error, pre_right, target_error, right_orien, right_target,
           push_ras, pop_ras, redirect_valid, redirect_pc, br_cnt, miss_cnt
  );

  modport master (
    output flush, br_valid, br_pc, br_type, br_taken, br_target,
           pred_en, pred_taken, pred_target, pred_index, redirect_ack,
    input  br_ready, operate_en, operate_pc, operate_index, add_entry, delete_entry,
           pre_error, pre_right, target_error, right_orien, right_target,
           push_ras, pop_ras, redirect_valid, redirect_pc, br_cnt, miss_cnt
  );
endinterface

// File: rtl/btb_update_ctrl.sv
// Decode-stage branch resolver: classifies prediction vs. outcome, issues one registered
// BTB update per accepted instruction and holds an IF redirect on mispredict.
//
// state | meaning
// IDLE  | ready for the next instruction
// REDIR | redirect_valid held until IF acks (or flush)
module btb_update_ctrl #(
  parameter int IDXW = 5,
  parameter int CNTW = 32
) (
  input  logic           clk,
  input  logic           reset,
  btb_update_ctrl_if.slave bus
);
  typedef enum logic {ST_IDLE, ST_REDIR} state_t;

  state_t          r_state, w_state_nxt;
  logic            r_operate_en, r_add, r_del, r_perr, r_pright, r_terr;
  logic            r_orien, r_push, r_pop;
  logic [31:0]     r_operate_pc, r_right_target, r_redirect_pc;
  logic [IDXW-1:0] r_operate_index;
  logic [CNTW-1:0] r_br_cnt, r_miss_cnt;

  logic        w_accept, w_taken, w_none, w_call, w_ret, w_mis, w_op, w_upd;
  logic        w_add, w_del, w_perr, w_pright, w_terr;
  logic [31:0] w_pc4, w_pred_next, w_act_next;

  assign w_none   = (bus.br_type == 3'd0);
  assign w_call   = (bus.br_type == 3'd3);
  assign w_ret    = (bus.br_type == 3'd4);
  // Unconditional kinds (b, bl, jirl) always resolve taken.
  assign w_taken  = bus.br_taken | (bus.br_type inside {3'd2, 3'd3, 3'd4, 3'd5});
  assign w_pc4    = bus.br_pc + 32'd4;
  assign w_pred_next = (bus.pred_en && bus.pred_taken) ? bus.pred_target : w_pc4;
  assign w_act_next  = w_taken ? bus.br_target : w_pc4;
  assign w_mis    = (w_pred_next != w_act_next);
  assign w_accept = bus.br_valid && bus.br_ready && !bus.flush;

  always_comb begin
    w_add    = 1'b0;
    w_del    = 1'b0;
    w_perr   = 1'b0;
    w_pright = 1'b0;
    w_terr   = 1'b0;
    if (w_none) begin
      w_del = bus.pred_en;
    end else if (!bus.pred_en) begin
      w_add = w_taken;
    end else if (bus.pred_taken != w_taken) begin
      w_perr = 1'b1;
    end else if (w_taken && (bus.pred_target != bus.br_target) && !w_ret) begin
      // RET targets come from the RAS, so a stale BTB target is not an entry error.
      w_terr = 1'b1;
    end else begin
      w_pright = 1'b1;
    end
  end

  assign w_op  = w_add | w_del | w_perr | w_pright | w_terr | w_call | w_ret;
  assign w_upd = w_accept && w_op;

  always_comb begin
    w_state_nxt = r_state;
    if (bus.flush) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (w_accept && w_mis) w_state_nxt = ST_REDIR;
        ST_REDIR: if (bus.redirect_ack)  w_state_nxt = ST_IDLE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_operate_en    <= 1'b0;
      r_add           <= 1'b0;
      r_del           <= 1'b0;
      r_perr          <= 1'b0;
      r_pright        <= 1'b0;
      r_terr          <= 1'b0;
      r_orien         <= 1'b0;
      r_push          <= 1'b0;
      r_pop           <= 1'b0;
      r_operate_pc    <= '0;
      r_right_target  <= '0;
      r_operate_index <= '0;
      r_redirect_pc   <= '0;
      r_br_cnt        <= '0;
      r_miss_cnt      <= '0;
    end else begin
      r_operate_en    <= w_upd;
      r_add           <= w_upd && w_add;
      r_del           <= w_upd && w_del;
      r_perr          <= w_upd && w_perr;
      r_pright        <= w_upd && w_pright;
      r_terr          <= w_upd && w_terr;
      r_orien         <= w_upd && w_taken;
      r_push          <= w_upd && w_call;
      r_pop           <= w_upd && w_ret;
      r_operate_pc    <= w_upd ? bus.br_pc      : '0;
      r_right_target  <= w_upd ? bus.br_target  : '0;
      r_operate_index <= w_upd ? bus.pred_index : '0;
      if (w_accept && w_mis)
        r_redirect_pc <= w_act_next;
      if (w_accept && !w_none && (r_br_cnt != '1))
        r_br_cnt <= r_br_cnt + CNTW'(1);
      if (w_accept && w_mis && (r_miss_cnt != '1))
        r_miss_cnt <= r_miss_cnt + CNTW'(1);
    end
  end

  assign bus.br_ready       = (r_state == ST_IDLE);
  assign bus.redirect_valid = (r_state == ST_REDIR);
  assign bus.redirect_pc    = r_redirect_pc;
  assign bus.operate_en     = r_operate_en;
  assign bus.operate_pc     = r_operate_pc;
  assign bus.operate_index  = r_operate_index;
  assign bus.add_entry      = r_add;
  assign bus.delete_entry   = r_del;
  assign bus.pre_error      = r_perr;
  assign bus.pre_right      = r_pright;
  assign bus.target_error   = r_terr;
  assign bus.right_orien    = r_orien;
  assign bus.right_target   = r_right_target;
  assign bus.push_ras       = r_push;
  assign bus.pop_ras        = r_pop;
  assign bus.br_cnt         = r_br_cnt;
  assign bus.miss_cnt       = r_miss_cnt;
endmodule

// File: tb/tb_btb_update_ctrl.sv
// Bench for btb_update_ctrl: directed cases plus randomized traffic against a next-PC
// reference model; a 2-bit-counter twin shares the stimulus to exercise saturation.
module tb_btb_update_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  btb_update_ctrl_if #(.IDXW(5), .CNTW(32)) a();
  btb_update_ctrl_if #(.IDXW(5), .CNTW(2))  b();

  assign b.flush        = a.flush;
  assign b.br_valid     = a.br_valid;
  assign b.br_pc        = a.br_pc;
  assign b.br_type      = a.br_type;
  assign b.br_taken     = a.br_taken;
  assign b.br_target    = a.br_target;
  assign b.pred_en      = a.pred_en;
  assign b.pred_taken   = a.pred_taken;
  assign b.pred_target  = a.pred_target;
  assign b.pred_index   = a.pred_index;
  assign b.redirect_ack = a.redirect_ack;

  btb_update_ctrl #(.IDXW(5), .CNTW(32)) dut  (.clk(clk), .reset(reset), .bus(a));
  btb_update_ctrl #(.IDXW(5), .CNTW(2))  dut2 (.clk(clk), .reset(reset), .bus(b));

  typedef struct packed {
    logic op, add, del, perr, pright, terr, orien, push, pop, mis;
    logic [31:0] nxt;
  } exp_t;

  int total = 0;
  int bad   = 0;
  int exp_br = 0;
  int exp_miss = 0;
  exp_t ex;

  // Reference: predicted vs. actual next PC and first-match classification.
  function automatic exp_t model(logic [2:0] t, logic [31:0] pc, logic tk, logic [31:0] tgt,
                                 logic pen, logic pt, logic [31:0] ptgt);
    exp_t e;
    logic taken;
    logic [31:0] pn, an;
    e = '0;
    taken = tk || (t >= 3'd2 && t <= 3'd5);
    pn = (pen && pt) ? ptgt : pc + 32'd4;
    an = taken ? tgt : pc + 32'd4;
    e.mis = (pn != an);
    e.nxt = an;
    e.orien = taken;
    if (t == 3'd0) e.del = pen;
    else if (!pen) e.add = taken;
    else if (pt != taken) e.perr = 1'b1;
    else if (taken && ptgt != tgt && t != 3'd4) e.terr = 1'b1;
    else e.pright = 1'b1;
    e.op = e.add | e.del | e.perr | e.pright | e.terr | (t == 3'd3) | (t == 3'd4);
    e.push = e.op && (t == 3'd3);
    e.pop  = e.op && (t == 3'd4);
    e.orien = e.op && taken;
    return e;
  endfunction

  function automatic int sat2(int x);
    return (x > 3) ? 3 : x;
  endfunction

  // Present one instruction, wait for the registered result, update the counter model.
  task automatic send(input logic [2:0] t, input logic [31:0] pc, input logic tk,
                      input logic [31:0] tgt, input logic pen, input logic pt,
                      input logic [31:0] ptgt, input logic [4:0] idx);
    int w;
    w = 0;
    while (a.br_ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    total++;
    if (w >= 20) begin bad++; $display("FAIL ready_timeout got=%b want=1", a.br_ready); end
    a.br_type = t; a.br_pc = pc; a.br_taken = tk; a.br_target = tgt;
    a.pred_en = pen; a.pred_taken = pt; a.pred_target = ptgt; a.pred_index = idx;
    a.br_valid = 1'b1;
    @(negedge clk);
    a.br_valid = 1'b0;
    ex = model(t, pc, tk, tgt, pen, pt, ptgt);
    if (t != 3'd0) exp_br++;
    if (ex.mis) exp_miss++;
  endtask

  task automatic ack_redirect(input int hold);
    repeat (hold) @(negedge clk);
    a.redirect_ack = 1'b1;
    @(negedge clk);
    a.redirect_ack = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    a.flush = 0; a.br_valid = 0; a.br_pc = 0; a.br_type = 0; a.br_taken = 0; a.br_target = 0;
    a.pred_en = 0; a.pred_taken = 0; a.pred_target = 0; a.pred_index = 0; a.redirect_ack = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++; if (a.br_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", a.br_ready); end
    total++; if (a.operate_en !== 1'b0) begin bad++; $display("FAIL rst_op got=%b want=0", a.operate_en); end
    total++; if (a.redirect_valid !== 1'b0) begin bad++; $display("FAIL rst_redir got=%b want=0", a.redirect_valid); end
    total++; if (a.redirect_pc !== 32'd0) begin bad++; $display("FAIL rst_rpc got=%h want=0", a.redirect_pc); end
    total++; if (a.br_cnt !== 32'd0 || a.miss_cnt !== 32'd0) begin bad++; $display("FAIL rst_cnt got=%0d/%0d want=0/0", a.br_cnt, a.miss_cnt); end
  endtask

  task automatic test_saturate;
    for (int i = 0; i < 2; i++) begin
      send(3'd1, 32'h1c001000 + 32'(i * 16), 1'b1, 32'h1c002000, 1'b0, 1'b0, 32'd0, 5'd0);
      ack_redirect(0);
    end
    total++; if (b.br_cnt !== 2'd2 || b.miss_cnt !== 2'd2) begin bad++; $display("FAIL sat_pre got=%0d/%0d want=2/2", b.br_cnt, b.miss_cnt); end
    for (int i = 0; i < 2; i++) begin
      send(3'd1, 32'h1c003000, 1'b1, 32'h1c004000, 1'b0, 1'b0, 32'd0, 5'd0);
      ack_redirect(0);
    end
    send(3'd1, 32'hFFFFFFFC, 1'b0, 32'h00000100, 1'b1, 1'b1, 32'h00000100, 5'd9);
    total++; if (a.redirect_valid !== 1'b1 || a.redirect_pc !== 32'd0) begin bad++; $display("FAIL wrap_rpc got=%b/%h want=1/00000000", a.redirect_valid, a.redirect_pc); end
    total++; if (a.pre_error !== 1'b1) begin bad++; $display("FAIL wrap_class got=%b want=1", a.pre_error); end
    ack_redirect(0);
    total++; if (b.br_cnt !== 2'd3 || b.miss_cnt !== 2'd3) begin bad++; $display("FAIL sat_cnt got=%0d/%0d want=3/3", b.br_cnt, b.miss_cnt); end
    total++; if (a.br_cnt !== 32'd5 || a.miss_cnt !== 32'd5) begin bad++; $display("FAIL sat_wide got=%0d/%0d want=5/5", a.br_cnt, a.miss_cnt); end
  endtask

  task automatic test_directed;
    send(3'd1, 32'h1c000100, 1'b1, 32'h1c000200, 1'b0, 1'b0, 32'd0, 5'd0);
    total++; if (a.operate_en !== 1'b1 || a.add_entry !== 1'b1) begin bad++; $display("FAIL c1_add got=%b%b want=11", a.operate_en, a.add_entry); end
    total++; if (a.redirect_valid !== 1'b1 || a.redirect_pc !== 32'h1c000200) begin bad++; $display("FAIL c1_rpc got=%b/%h want=1/1c000200", a.redirect_valid, a.redirect_pc); end
    total++; if (a.miss_cnt !== 32'(exp_miss)) begin bad++; $display("FAIL c1_miss got=%0d want=%0d", a.miss_cnt, exp_miss); end
    ack_redirect(1);
    send(3'd1, 32'h1c000100, 1'b0, 32'h1c000200, 1'b1, 1'b1, 32'h1c000200, 5'd3);
    total++; if (a.pre_error !== 1'b1 || a.right_orien !== 1'b0 || a.operate_index !== 5'd3) begin bad++; $display("FAIL c2_perr got=%b/%b/%0d want=1/0/3", a.pre_error, a.right_orien, a.operate_index); end
    total++; if (a.redirect_pc !== 32'h1c000104) begin bad++; $display("FAIL c2_rpc got=%h want=1c000104", a.redirect_pc); end
    ack_redirect(0);
    total++; if (a.redirect_valid !== 1'b0 || a.br_ready !== 1'b1) begin bad++; $display("FAIL c2_ack1 got=%b/%b want=0/1", a.redirect_valid, a.br_ready); end
    send(3'd3, 32'h1c000300, 1'b1, 32'h1c000500, 1'b1, 1'b1, 32'h1c000500, 5'd7);
    total++; if (a.push_ras !== 1'b1 || a.pop_ras !== 1'b0 || a.pre_right !== 1'b1 || a.redirect_valid !== 1'b0) begin bad++; $display("FAIL c3_call got=%b%b%b%b want=1010", a.push_ras, a.pop_ras, a.pre_right, a.redirect_valid); end
    send(3'd4, 32'h1c000504, 1'b1, 32'h1c000304, 1'b1, 1'b1, 32'h1c000304, 5'd8);
    total++; if (a.push_ras !== 1'b0 || a.pop_ras !== 1'b1 || a.pre_right !== 1'b1 || a.redirect_valid !== 1'b0) begin bad++; $display("FAIL c3_ret got=%b%b%b%b want=0110", a.push_ras, a.pop_ras, a.pre_right, a.redirect_valid); end
    send(3'd0, 32'h1c000400, 1'b0, 32'd0, 1'b1, 1'b1, 32'h1c000800, 5'd2);
    total++; if (a.delete_entry !== 1'b1 || a.redirect_pc !== 32'h1c000404) begin bad++; $display("FAIL c4_del got=%b/%h want=1/1c000404", a.delete_entry, a.redirect_pc); end
    total++; if (a.br_cnt !== 32'(exp_br)) begin bad++; $display("FAIL c4_brcnt got=%0d want=%0d", a.br_cnt, exp_br); end
    ack_redirect(0);
  endtask

  task automatic test_redirect_hold_flush;
    send(3'd1, 32'h1c000600, 1'b1, 32'h1c000700, 1'b0, 1'b0, 32'd0, 5'd1);
    a.br_type = 3'd2; a.br_pc = 32'h1c000900; a.br_target = 32'h1c000a00; a.pred_en = 1'b0;
    a.br_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (a.redirect_valid !== 1'b1 || a.redirect_pc !== 32'h1c000700 || a.br_ready !== 1'b0) begin bad++; $display("FAIL hold%0d got=%b/%h/%b want=1/1c000700/0", i, a.redirect_valid, a.redirect_pc, a.br_ready); end
    end
    a.flush = 1'b1;
    @(negedge clk);
    a.flush = 1'b0;
    a.br_valid = 1'b0;
    total++; if (a.redirect_valid !== 1'b0 || a.br_ready !== 1'b1 || a.operate_en !== 1'b0) begin bad++; $display("FAIL flush_redir got=%b/%b/%b want=0/1/0", a.redirect_valid, a.br_ready, a.operate_en); end
    total++; if (a.br_cnt !== 32'(exp_br) || a.miss_cnt !== 32'(exp_miss)) begin bad++; $display("FAIL flush_cnt got=%0d/%0d want=%0d/%0d", a.br_cnt, a.miss_cnt, exp_br, exp_miss); end
  endtask

  task automatic test_flush_update;
    a.br_type = 3'd1; a.br_pc = 32'h1c000b00; a.br_taken = 1'b1; a.br_target = 32'h1c000c00;
    a.pred_en = 1'b0; a.br_valid = 1'b1; a.flush = 1'b1;
    @(negedge clk);
    a.flush = 1'b0; a.br_valid = 1'b0;
    total++; if (a.operate_en !== 1'b0 || a.redirect_valid !== 1'b0 || a.br_cnt !== 32'(exp_br)) begin bad++; $display("FAIL flush_block got=%b/%b/%0d want=0/0/%0d", a.operate_en, a.redirect_valid, a.br_cnt, exp_br); end
    send(3'd1, 32'h1c000d00, 1'b1, 32'h1c000e00, 1'b0, 1'b0, 32'd0, 5'd4);
    a.flush = 1'b1;
    #1;
    total++; if (a.operate_en !== 1'b1 || a.add_entry !== 1'b1 || a.operate_pc !== 32'h1c000d00) begin bad++; $display("FAIL flush_keep got=%b/%b/%h want=1/1/1c000d00", a.operate_en, a.add_entry, a.operate_pc); end
    @(negedge clk);
    a.flush = 1'b0;
    total++; if (a.redirect_valid !== 1'b0 || a.operate_en !== 1'b0) begin bad++; $display("FAIL flush_drop got=%b/%b want=0/0", a.redirect_valid, a.operate_en); end
  endtask

  task automatic test_back_to_back;
    send(3'd1, 32'h1c001100, 1'b0, 32'h1c001800, 1'b1, 1'b0, 32'h1c001800, 5'd5);
    total++; if (a.operate_en !== 1'b1 || a.pre_right !== 1'b1 || a.operate_pc !== 32'h1c001100) begin bad++; $display("FAIL b2b_a got=%b/%b/%h want=1/1/1c001100", a.operate_en, a.pre_right, a.operate_pc); end
    send(3'd1, 32'h1c001104, 1'b0, 32'h1c001900, 1'b1, 1'b0, 32'h1c001900, 5'd6);
    total++; if (a.operate_en !== 1'b1 || a.operate_pc !== 32'h1c001104 || a.operate_index !== 5'd6) begin bad++; $display("FAIL b2b_b got=%b/%h/%0d want=1/1c001104/6", a.operate_en, a.operate_pc, a.operate_index); end
    @(negedge clk);
    total++; if (a.operate_en !== 1'b0 || a.pre_right !== 1'b0) begin bad++; $display("FAIL b2b_pulse got=%b/%b want=0/0", a.operate_en, a.pre_right); end
  endtask

  task automatic test_random;
    logic [2:0] t; logic [31:0] pc, tgt, ptgt; logic tk, pen, pt; logic [4:0] idx;
    logic [7:0] ov, ev;
    int hold;
    for (int n = 0; n < 300; n++) begin
      t   = 3'($urandom_range(0, 5));
      pc  = {$urandom(), 2'b00} >> 0;
      pc  = {pc[31:2], 2'b00};
      tk  = 1'($urandom);
      tgt = ($urandom_range(0, 7) == 0) ? pc + 32'd4 : {$urandom(), 2'b00} >> 2 << 2;
      pen = 1'($urandom);
      pt  = 1'($urandom);
      ptgt = ($urandom_range(0, 2) != 0) ? tgt : ({$urandom(), 2'b00} >> 2 << 2);
      idx = 5'($urandom);
      send(t, pc, tk, tgt, pen, pt, ptgt, idx);
      ov = {a.operate_en, a.add_entry, a.delete_entry, a.pre_error, a.pre_right, a.target_error, a.push_ras, a.pop_ras};
      ev = {ex.op, ex.add, ex.del, ex.perr, ex.pright, ex.terr, ex.push, ex.pop};
      total++; if (ov !== ev) begin bad++; $display("FAIL rnd%0d_class t=%0d got=%b want=%b", n, t, ov, ev); end
      if (ex.op) begin
        total++; if (a.operate_pc !== pc || a.operate_index !== idx || a.right_target !== tgt || a.right_orien !== ex.orien) begin bad++; $display("FAIL rnd%0d_fields got=%h/%0d/%h/%b want=%h/%0d/%h/%b", n, a.operate_pc, a.operate_index, a.right_target, a.right_orien, pc, idx, tgt, ex.orien); end
      end
      total++; if (a.redirect_valid !== ex.mis) begin bad++; $display("FAIL rnd%0d_redir got=%b want=%b", n, a.redirect_valid, ex.mis); end
      total++; if (a.br_cnt !== 32'(exp_br) || a.miss_cnt !== 32'(exp_miss) || b.br_cnt !== 2'(sat2(exp_br)) || b.miss_cnt !== 2'(sat2(exp_miss))) begin bad++; $display("FAIL rnd%0d_cnt got=%0d/%0d/%0d/%0d want=%0d/%0d/%0d/%0d", n, a.br_cnt, a.miss_cnt, b.br_cnt, b.miss_cnt, exp_br, exp_miss, sat2(exp_br), sat2(exp_miss)); end
      if (ex.mis) begin
        total++; if (a.redirect_pc !== ex.nxt) begin bad++; $display("FAIL rnd%0d_rpc got=%h want=%h", n, a.redirect_pc, ex.nxt); end
        hold = $urandom_range(0, 3);
        for (int h = 0; h < hold; h++) begin
          @(negedge clk);
          total++; if (a.redirect_valid !== 1'b1 || a.redirect_pc !== ex.nxt || a.br_ready !== 1'b0) begin bad++; $display("FAIL rnd%0d_hold got=%b/%h/%b want=1/%h/0", n, a.redirect_valid, a.redirect_pc, a.br_ready, ex.nxt); end
        end
        ack_redirect(0);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_saturate();
    test_directed();
    test_redirect_hold_flush();
    test_flush_update();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
